// File: rtl/mem_stream_reader_if.sv
// -----------------------------------------------------------------------------
// mem_stream_reader_if
//
// Bundles every non-clock, non-reset signal of mem_stream_reader.
//   Command   : start, base_addr, count, dw          (controller -> reader)
//   Status    : busy, done                           (reader -> controller)
//   Memory    : mem_we, mem_dw, mem_addr, mem_in     (reader -> memory)
//               mem_out                              (memory -> reader)
//   Stream    : out_valid, out_data, out_last        (reader -> consumer)
//               out_ready                            (consumer -> reader)
//
// Modports:
//   slave  - the reader itself
//   master - everything around it (controller, memory and consumer)
// -----------------------------------------------------------------------------
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 64
`endif

interface mem_stream_reader_if #(
  parameter int ADDR_W = `MEM_ADDR_WIDTH,
  parameter int DATA_W = `MEM_DATA_WIDTH
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       count;
  logic [1:0]        dw;
  logic              busy;
  logic              done;

  logic              mem_we;
  logic [1:0]        mem_dw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  start, base_addr, count, dw, mem_out, out_ready,
    output busy, done, mem_we, mem_dw, mem_addr, mem_in, out_valid, out_data, out_last
  );

  modport master (
    output start, base_addr, count, dw, mem_out, out_ready,
    input  busy, done, mem_we, mem_dw, mem_addr, mem_in, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
//
// Streams `count` elements of size (8 << dw) bits from a fixed-latency memory,
// starting at byte address base_addr, onto a valid/ready output stream.
// Reads are issued one per cycle as long as the reads still in flight plus
// the elements already buffered leave room in the output FIFO, so returning
// data always has a slot and nothing is dropped under backpressure.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mem_stream_reader_if.slave (command, status, memory, stream)
//
// Parameters:
//   ADDR_W - byte-address width
//   DATA_W - memory data width
//   RD_LAT - cycles from mem_addr to valid mem_out (>= 1)
//   FIFO_D - output buffer depth (>= RD_LAT + 1)
// -----------------------------------------------------------------------------
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 64
`endif

module mem_stream_reader #(
  parameter int ADDR_W = `MEM_ADDR_WIDTH,
  parameter int DATA_W = `MEM_DATA_WIDTH,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_stream_reader_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int SUM_W = CNT_W + 2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        dw_q, dw_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;     // reads issued so far
  logic [15:0]       out_cnt_q, out_cnt_d;   // elements handed to the consumer
  logic [RD_LAT-1:0] inflight_q, inflight_d; // bit i: a read issued i+1 cycles ago

  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [SUM_W-1:0]  outstanding;
  logic [SUM_W-1:0]  used;
  logic [ADDR_W-1:0] stride;
  logic [DATA_W-1:0] elem_mask;
  logic              issue, push, pop, out_valid;
  logic              last_issue, last_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Read issue and return tracking
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + SUM_W'(inflight_q[i]);
    end
  end

  // Every in-flight read already owns a FIFO slot, so the FIFO cannot overflow.
  assign used       = outstanding + SUM_W'(fifo_cnt_q);
  assign issue      = (state_q == ST_RUN) && (used < SUM_W'(FIFO_D));
  assign last_issue = issue && (rd_cnt_q == count_q - 16'd1);
  assign stride     = ADDR_W'(1) << dw_q;

  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  // A read leaving the tracking pipe has its data on mem_out this cycle.
  assign push = inflight_q[RD_LAT-1];

  always_comb begin
    elem_mask = '1;
    if (dw_q != 2'd3) begin
      elem_mask = (DATA_W'(1) << (8 << dw_q)) - DATA_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign last_pop  = pop && (out_cnt_q == count_q - 16'd1);

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and occupancy count are reset, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.mem_out & elem_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dw_d      = dw_q;
    count_d   = count_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dw_d      = bus.dw;
          count_d   = bus.count;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          if (bus.count != 16'd0) begin
            addr_d  = bus.base_addr;
            state_d = ST_RUN;
          end else begin
            // Nothing to read: mem_addr keeps its old value.
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // mem_addr shows the read being issued; it advances only after a read
    // goes out and stops on the final address of the transfer.
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
      if (!last_issue) begin
        addr_d = addr_q + stride;
      end
    end
    if (pop) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      dw_q       <= '0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dw_q       <= dw_d;
      count_q    <= count_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // A push into a full FIFO without a simultaneous pop would overwrite live data.
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_D))));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.mem_we    = 1'b0;
  assign bus.mem_in    = '0;
  assign bus.mem_dw    = dw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid && (out_cnt_q == count_q - 16'd1);

endmodule
